// File: rtl/ccip_txn_tracker.sv
// Outstanding CCI-P transaction tracker: pairs read/write requests with their responses by
// mdata, keeps live outstanding counts and flags collisions, orphans and timeouts.
module ccip_txn_tracker #(
   parameter int IDX_W   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic           clk,
   input  logic           SoftReset,
   input  logic           C0TxRdValid,
   input  logic [15:0]    C0TxMdata,
   input  logic [1:0]     C0TxLen,
   input  logic           C0RxRdValid,
   input  logic [15:0]    C0RxMdata,
   input  logic           C1TxWrValid,
   input  logic [15:0]    C1TxMdata,
   input  logic [1:0]     C1TxLen,
   input  logic           C1RxWrValid,
   input  logic [15:0]    C1RxMdata,
   output logic [IDX_W:0] rd_outstanding,
   output logic [IDX_W:0] wr_outstanding,
   output logic           drain_idle,
   output logic           err_valid,
   output logic [2:0]     err_code,
   output logic [15:0]    err_mdata,
   output logic [15:0]    err_count
);
   localparam int N     = 1 << IDX_W;
   localparam int CW    = IDX_W + 1;
   localparam int AGE_W = $clog2(TIMEOUT + 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT);
   localparam logic [AGE_W-1:0] AGE_MAX   = '1;

   logic             w_rsp_v    [2];
   logic [15:0]      w_rsp_md   [2];
   logic             w_req_v    [2];
   logic [15:0]      w_req_md   [2];
   logic [1:0]       w_req_len  [2];
   logic [CW-1:0]    w_cnt      [2];
   logic [CW-1:0]    w_cnt_next [2];
   logic             w_ev       [6];
   logic [15:0]      w_ev_md    [6];

   logic             w_any;
   logic [2:0]       w_code;
   logic [15:0]      w_md;
   logic [2:0]       w_num;
   logic [16:0]      w_sum;

   logic [IDX_W-1:0] r_scan_ptr;
   logic             r_idle;
   logic             r_err_valid;
   logic [2:0]       r_err_code;
   logic [15:0]      r_err_mdata;
   logic [15:0]      r_err_count;

   // channel 0 = reads, channel 1 = writes/fences
   assign w_rsp_v[0]   = C0RxRdValid;
   assign w_rsp_md[0]  = C0RxMdata;
   assign w_req_v[0]   = C0TxRdValid;
   assign w_req_md[0]  = C0TxMdata;
   assign w_req_len[0] = C0TxLen;
   assign w_rsp_v[1]   = C1RxWrValid;
   assign w_rsp_md[1]  = C1RxMdata;
   assign w_req_v[1]   = C1TxWrValid;
   assign w_req_md[1]  = C1TxMdata;
   assign w_req_len[1] = C1TxLen;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic             r_valid [N];
         logic [15:0]      r_tag   [N];
         logic [1:0]       r_rem   [N];
         logic [AGE_W-1:0] r_age   [N];
         logic [CW-1:0]    r_cnt;
         logic [IDX_W-1:0] w_ridx;
         logic [IDX_W-1:0] w_qidx;
         logic             w_hit;
         logic             w_rsp_free;
         logic             w_busy;
         logic             w_alloc;
         logic             w_coll;
         logic             w_orphan;
         logic             w_tout;

         assign w_ridx     = w_rsp_md[gi][IDX_W-1:0];
         assign w_qidx     = w_req_md[gi][IDX_W-1:0];
         assign w_hit      = w_rsp_v[gi] && r_valid[w_ridx] && (r_tag[w_ridx] == w_rsp_md[gi]);
         assign w_orphan   = w_rsp_v[gi] && !w_hit;
         assign w_rsp_free = w_hit && (r_rem[w_ridx] == 2'd0);
         // a response that retires the slot this cycle lets a same-index request allocate it
         assign w_busy     = r_valid[w_qidx] && !(w_rsp_free && (w_ridx == w_qidx));
         assign w_coll     = w_req_v[gi] && w_busy;
         assign w_alloc    = w_req_v[gi] && !w_busy;
         // scan looks at pre-update state; a matching response to the scanned slot wins
         assign w_tout     = r_valid[r_scan_ptr] && (r_age[r_scan_ptr] >= AGE_LIMIT) &&
                             !(w_hit && (w_ridx == r_scan_ptr));

         assign w_cnt[gi]      = r_cnt;
         assign w_cnt_next[gi] = r_cnt + CW'(w_alloc) - CW'(w_rsp_free) - CW'(w_tout);

         assign w_ev[gi*3]        = w_coll;
         assign w_ev_md[gi*3]     = w_req_md[gi];
         assign w_ev[gi*3+1]      = w_orphan;
         assign w_ev_md[gi*3+1]   = w_rsp_md[gi];
         assign w_ev[gi*3+2]      = w_tout;
         assign w_ev_md[gi*3+2]   = r_tag[r_scan_ptr];

         always_ff @(posedge clk or posedge SoftReset) begin
            if (SoftReset) begin
               r_cnt <= '0;
               for (int e = 0; e < N; e++) begin
                  r_valid[e] <= 1'b0;
               end
            end else begin
               r_cnt <= w_cnt_next[gi];
               for (int e = 0; e < N; e++) begin
                  if (w_tout && (r_scan_ptr == IDX_W'(e))) begin
                     r_valid[e] <= 1'b0;
                  end else if (w_alloc && (w_qidx == IDX_W'(e))) begin
                     r_valid[e] <= 1'b1;
                  end else if (w_rsp_free && (w_ridx == IDX_W'(e))) begin
                     r_valid[e] <= 1'b0;
                  end
               end
            end
         end

         // payload is only meaningful while the matching valid bit is set
         always_ff @(posedge clk) begin
            for (int e = 0; e < N; e++) begin
               if (w_alloc && (w_qidx == IDX_W'(e))) begin
                  r_tag[e] <= w_req_md[gi];
                  r_rem[e] <= w_req_len[gi];
                  r_age[e] <= '0;
               end else if (w_hit && (w_ridx == IDX_W'(e))) begin
                  if (r_rem[e] != 2'd0) begin
                     r_rem[e] <= r_rem[e] - 2'd1;
                  end
                  r_age[e] <= '0;
               end else if (r_valid[e] && (r_age[e] != AGE_MAX)) begin
                  r_age[e] <= r_age[e] + AGE_W'(1);
               end
            end
         end
      end
   endgenerate

   always_comb begin
      w_any  = 1'b0;
      w_code = 3'd0;
      w_md   = 16'd0;
      w_num  = 3'd0;
      for (int k = 5; k >= 0; k--) begin
         if (w_ev[k]) begin
            w_any  = 1'b1;
            w_code = 3'(k + 1);
            w_md   = w_ev_md[k];
         end
         w_num = w_num + {2'b00, w_ev[k]};
      end
   end

   assign w_sum = {1'b0, r_err_count} + {14'd0, w_num};

   always_ff @(posedge clk or posedge SoftReset) begin
      if (SoftReset) begin
         r_scan_ptr  <= '0;
         r_idle      <= 1'b1;
         r_err_valid <= 1'b0;
         r_err_code  <= 3'd0;
         r_err_mdata <= 16'd0;
         r_err_count <= 16'd0;
      end else begin
         r_scan_ptr  <= r_scan_ptr + IDX_W'(1);
         r_idle      <= (w_cnt_next[0] == '0) && (w_cnt_next[1] == '0);
         r_err_valid <= w_any;
         if (w_any) begin
            r_err_code  <= w_code;
            r_err_mdata <= w_md;
         end
         r_err_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
   end

   assign rd_outstanding = w_cnt[0];
   assign wr_outstanding = w_cnt[1];
   assign drain_idle     = r_idle;
   assign err_valid      = r_err_valid;
   assign err_code       = r_err_code;
   assign err_mdata      = r_err_mdata;
   assign err_count      = r_err_count;

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// Bench for ccip_txn_tracker: directed scenarios then random traffic, every cycle checked
// against a model that tracks outstanding requests by last-touch cycle number.
module tb_ccip_txn_tracker;
   localparam int IDX_W = 2;
   localparam int TO    = 16;
   localparam int N     = 1 << IDX_W;

   logic           clk = 1'b0;
   logic           SoftReset = 1'b1;
   logic           C0TxRdValid = 1'b0;
   logic [15:0]    C0TxMdata = 16'd0;
   logic [1:0]     C0TxLen = 2'd0;
   logic           C0RxRdValid = 1'b0;
   logic [15:0]    C0RxMdata = 16'd0;
   logic           C1TxWrValid = 1'b0;
   logic [15:0]    C1TxMdata = 16'd0;
   logic [1:0]     C1TxLen = 2'd0;
   logic           C1RxWrValid = 1'b0;
   logic [15:0]    C1RxMdata = 16'd0;
   logic [IDX_W:0] rd_outstanding;
   logic [IDX_W:0] wr_outstanding;
   logic           drain_idle;
   logic           err_valid;
   logic [2:0]     err_code;
   logic [15:0]    err_mdata;
   logic [15:0]    err_count;

   always #5 clk = ~clk;

   ccip_txn_tracker #(.IDX_W(IDX_W), .TIMEOUT(TO)) dut (
      .clk(clk), .SoftReset(SoftReset),
      .C0TxRdValid(C0TxRdValid), .C0TxMdata(C0TxMdata), .C0TxLen(C0TxLen),
      .C0RxRdValid(C0RxRdValid), .C0RxMdata(C0RxMdata),
      .C1TxWrValid(C1TxWrValid), .C1TxMdata(C1TxMdata), .C1TxLen(C1TxLen),
      .C1RxWrValid(C1RxWrValid), .C1RxMdata(C1RxMdata),
      .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
      .drain_idle(drain_idle), .err_valid(err_valid), .err_code(err_code),
      .err_mdata(err_mdata), .err_count(err_count)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // model: per channel, slot occupancy, tag, responses still owed, cycle of last touch
   bit          mv    [2][N];
   logic [15:0] mtag  [2][N];
   int          mrem  [2][N];
   int          mlast [2][N];
   int          m_scan, m_edge;
   bit          m_ev;
   int          m_code, m_md, m_errcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_count(input int c);
      int s = 0;
      for (int i = 0; i < N; i++) s += int'(mv[c][i]);
      return s;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < N; i++) begin
            mv[c][i] = 1'b0; mtag[c][i] = 16'd0; mrem[c][i] = 0; mlast[c][i] = 0;
         end
      m_scan = 0; m_edge = 0; m_ev = 1'b0; m_code = 0; m_md = 0; m_errcnt = 0;
   endtask

   task automatic model_step();
      bit          rv [2];
      bit          qv [2];
      logic [15:0] rmd [2];
      logic [15:0] qmd [2];
      int          ql [2];
      bit          evb [7];
      logic [15:0] evm [7];
      int          s, n;
      rv[0] = C0RxRdValid; rmd[0] = C0RxMdata; qv[0] = C0TxRdValid; qmd[0] = C0TxMdata; ql[0] = int'(C0TxLen);
      rv[1] = C1RxWrValid; rmd[1] = C1RxMdata; qv[1] = C1TxWrValid; qmd[1] = C1TxMdata; ql[1] = int'(C1TxLen);
      for (int k = 0; k < 7; k++) begin evb[k] = 1'b0; evm[k] = 16'd0; end
      s = m_scan % N;
      for (int c = 0; c < 2; c++) begin
         int ri, qi;
         bit hit, to;
         logic [15:0] tomd;
         ri = int'(rmd[c]) % N;
         qi = int'(qmd[c]) % N;
         hit  = rv[c] && mv[c][ri] && (mtag[c][ri] == rmd[c]);
         to   = mv[c][s] && ((m_edge - 1 - mlast[c][s]) >= TO) && !(hit && ri == s);
         tomd = mtag[c][s];
         if (hit) begin
            if (mrem[c][ri] == 0) mv[c][ri] = 1'b0;
            else mrem[c][ri]--;
            mlast[c][ri] = m_edge;
         end else if (rv[c]) begin
            evb[3*c+2] = 1'b1; evm[3*c+2] = rmd[c];
         end
         if (qv[c]) begin
            if (mv[c][qi]) begin
               evb[3*c+1] = 1'b1; evm[3*c+1] = qmd[c];
            end else begin
               mv[c][qi] = 1'b1; mtag[c][qi] = qmd[c]; mrem[c][qi] = ql[c]; mlast[c][qi] = m_edge;
            end
         end
         if (to) begin
            mv[c][s] = 1'b0; evb[3*c+3] = 1'b1; evm[3*c+3] = tomd;
         end
      end
      n = 0;
      for (int k = 6; k >= 1; k--) begin
         if (evb[k]) begin n++; m_code = k; m_md = int'(evm[k]); end
      end
      m_ev = (n > 0);
      m_errcnt = (m_errcnt + n > 16'hFFFF) ? 16'hFFFF : m_errcnt + n;
      m_scan++;
      m_edge++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("rd_outstanding", 32'(rd_outstanding), 32'(m_count(0)));
      chk("wr_outstanding", 32'(wr_outstanding), 32'(m_count(1)));
      chk("drain_idle", 32'(drain_idle), 32'((m_count(0) == 0) && (m_count(1) == 0)));
      chk("err_valid", 32'(err_valid), 32'(m_ev));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("err_mdata", 32'(err_mdata), 32'(m_md));
      chk("err_count", 32'(err_count), 32'(m_errcnt));
      $display("cyc %0d: rd=%0d wr=%0d idle=%0b ev=%0b code=%0d md=%04h cnt=%0d",
               m_edge, rd_outstanding, wr_outstanding, drain_idle, err_valid, err_code, err_mdata, err_count);
   endtask

   task automatic idle_inputs();
      C0TxRdValid = 1'b0; C0RxRdValid = 1'b0; C1TxWrValid = 1'b0; C1RxWrValid = 1'b0;
      C0TxMdata = 16'd0; C0RxMdata = 16'd0; C1TxMdata = 16'd0; C1RxMdata = 16'd0;
      C0TxLen = 2'd0; C1TxLen = 2'd0;
   endtask

   task automatic drain();
      int k = 0;
      while ((rd_outstanding != 0 || wr_outstanding != 0) && k < 60) begin
         step();
         k++;
      end
      chk("drain_done", 32'(drain_idle), 32'd1);
   endtask

   initial begin
      int seen, lat, wr_before, cnt_before, ci;
      model_reset();
      #12;
      chk("rst_rd", 32'(rd_outstanding), 32'd0);
      chk("rst_idle", 32'(drain_idle), 32'd1);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      @(negedge clk);
      SoftReset = 1'b0;

      // multi-CL read: four responses retire it
      C0TxRdValid = 1'b1; C0TxMdata = 16'h0005; C0TxLen = 2'd3;
      step();
      chk("t1_rd_alloc", 32'(rd_outstanding), 32'd1);
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         C0RxRdValid = 1'b1; C0RxMdata = 16'h0005;
         step();
         if (k < 3) chk("t1_rd_hold", 32'(rd_outstanding), 32'd1);
      end
      idle_inputs();
      chk("t1_rd_done", 32'(rd_outstanding), 32'd0);
      chk("t1_idle", 32'(drain_idle), 32'd1);
      chk("t1_no_err", 32'(err_valid), 32'd0);

      // write collision on index 2
      C1TxWrValid = 1'b1; C1TxMdata = 16'h0012; C1TxLen = 2'd0;
      step();
      C1TxMdata = 16'h0022;
      step();
      idle_inputs();
      chk("t2_code", 32'(err_code), 32'd4);
      chk("t2_mdata", 32'(err_mdata), 32'h0022);
      chk("t2_wr", 32'(wr_outstanding), 32'd1);
      chk("t2_count", 32'(err_count), 32'd1);

      // read orphan
      C0RxRdValid = 1'b1; C0RxMdata = 16'h0007;
      step();
      idle_inputs();
      chk("t3_valid", 32'(err_valid), 32'd1);
      chk("t3_code", 32'(err_code), 32'd2);
      chk("t3_mdata", 32'(err_mdata), 32'h0007);
      C1RxWrValid = 1'b1; C1RxMdata = 16'h0012;
      step();
      idle_inputs();
      drain();

      // read timeout
      C0TxRdValid = 1'b1; C0TxMdata = 16'h0001; C0TxLen = 2'd0;
      step();
      idle_inputs();
      seen = 0; lat = 0;
      for (int k = 1; k <= 24 && seen == 0; k++) begin
         step();
         if (err_valid && err_code == 3'd3 && err_mdata == 16'h0001) begin seen = 1; lat = k; end
      end
      chk("t4_timeout_seen", 32'(seen), 32'd1);
      chk("t4_latency_ok", 32'(lat >= TO + 1 && lat <= TO + N), 32'd1);
      chk("t4_rd_zero", 32'(rd_outstanding), 32'd0);
      drain();

      // same-cycle free + realloc on C1 with a C0 orphan
      C1TxWrValid = 1'b1; C1TxMdata = 16'h0003; C1TxLen = 2'd0;
      step();
      wr_before = int'(wr_outstanding);
      cnt_before = int'(err_count);
      C1RxWrValid = 1'b1; C1RxMdata = 16'h0003;
      C0RxRdValid = 1'b1; C0RxMdata = 16'h0009;
      step();
      idle_inputs();
      chk("t5_code", 32'(err_code), 32'd2);
      chk("t5_mdata", 32'(err_mdata), 32'h0009);
      chk("t5_count", 32'(err_count), 32'(cnt_before + 1));
      chk("t5_wr", 32'(wr_outstanding), 32'(wr_before));
      C1RxWrValid = 1'b1; C1RxMdata = 16'h0003;
      step();
      idle_inputs();

      // asynchronous reset with reads in flight
      C0TxRdValid = 1'b1; C0TxLen = 2'd0;
      C0TxMdata = 16'h0010; step();
      C0TxMdata = 16'h0021; step();
      C0TxMdata = 16'h0032; step();
      idle_inputs();
      chk("t6_rd_before", 32'(rd_outstanding), 32'd3);
      #2;
      SoftReset = 1'b1;
      #1;
      chk("t6_rst_rd", 32'(rd_outstanding), 32'd0);
      chk("t6_rst_idle", 32'(drain_idle), 32'd1);
      chk("t6_rst_count", 32'(err_count), 32'd0);
      chk("t6_rst_code", 32'(err_code), 32'd0);
      model_reset();
      @(negedge clk);
      SoftReset = 1'b0;
      C0RxRdValid = 1'b1; C0RxMdata = 16'h0010;
      step();
      idle_inputs();
      chk("t6_old_tag_code", 32'(err_code), 32'd2);
      chk("t6_old_tag_mdata", 32'(err_mdata), 32'h0010);

      // random traffic; responses often reuse live tags so hits occur
      for (int k = 0; k < 400; k++) begin
         C0TxRdValid = ($urandom_range(0, 2) == 0);
         C0TxMdata   = 16'($urandom_range(0, 31));
         C0TxLen     = 2'($urandom_range(0, 3));
         C1TxWrValid = ($urandom_range(0, 2) == 0);
         C1TxMdata   = 16'($urandom_range(0, 31));
         C1TxLen     = 2'($urandom_range(0, 3));
         C0RxRdValid = ($urandom_range(0, 1) == 0);
         ci = $urandom_range(0, N - 1);
         C0RxMdata   = ($urandom_range(0, 3) != 0) ? mtag[0][ci] : 16'($urandom_range(0, 31));
         C1RxWrValid = ($urandom_range(0, 1) == 0);
         ci = $urandom_range(0, N - 1);
         C1RxMdata   = ($urandom_range(0, 3) != 0) ? mtag[1][ci] : 16'($urandom_range(0, 31));
         step();
      end
      idle_inputs();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
